// File: rtl/dice_rng_display_if.sv
// Game-controller <-> dice RNG / display bundle: seed strobe, roll values,
// digits to show and the seven-segment drive.
interface dice_rng_display_if;
  logic       seed_en;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [6:0] seg;
  logic [3:0] anode;

  modport master (
    output seed_en, digit0, digit1, digit2, digit3,
    input  d0, d1, d2, d3, seg, anode
  );

  modport slave (
    input  seed_en, digit0, digit1, digit2, digit3,
    output d0, d1, d2, d3, seg, anode
  );
endinterface

// File: rtl/dice_rng_display.sv
// Free-running 32-bit Galois LFSR producing four 0..10 roll values, plus a
// four-digit multiplexed common-anode seven-segment driver.
module dice_rng_display #(
  parameter int          REFRESH_BITS = 18,
  parameter logic [31:0] SEED_XOR     = 32'hACE12B3D
) (
  input  logic                clk,
  input  logic                rst,
  dice_rng_display_if.slave   bus
);

  localparam logic [31:0] TAPS = 32'h80200003;

  function automatic logic [3:0] mod11(input logic [7:0] b);
    logic [7:0] r;
    r = b % 8'd11;
    return r[3:0];
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      4'd10:   s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [31:0]             cnt_r;
  logic [31:0]             lfsr_r;
  logic [REFRESH_BITS-1:0] rcnt_r;
  logic [6:0]              seg_r;
  logic [3:0]              anode_r;

  logic [31:0] seed_s;
  logic [31:0] lfsr_next_s;
  logic [1:0]  sel_s;
  logic [3:0]  digit_sel_s;

  assign sel_s  = rcnt_r[REFRESH_BITS-1 -: 2];
  assign seed_s = cnt_r ^ SEED_XOR;

  // Next LFSR state: seed load (zero seed forced to 1) or one Galois step
  always_comb begin
    lfsr_next_s = lfsr_r;
    if (bus.seed_en) begin
      if (seed_s == 32'h0) begin
        lfsr_next_s = 32'h00000001;
      end else begin
        lfsr_next_s = seed_s;
      end
    end else begin
      lfsr_next_s = (lfsr_r >> 1) ^ (lfsr_r[0] ? TAPS : 32'h0);
    end
  end

  // Digit selected by the current scan position
  always_comb begin
    digit_sel_s = 4'hF;
    case (sel_s)
      2'd0:    digit_sel_s = bus.digit0;
      2'd1:    digit_sel_s = bus.digit1;
      2'd2:    digit_sel_s = bus.digit2;
      2'd3:    digit_sel_s = bus.digit3;
      default: digit_sel_s = 4'hF;
    endcase
  end

  // Counters, LFSR and registered display drive
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r   <= 32'h0;
      lfsr_r  <= 32'h00000001;
      rcnt_r  <= '0;
      seg_r   <= 7'h7F;
      anode_r <= 4'hF;
    end else begin
      cnt_r   <= cnt_r + 32'd1;
      lfsr_r  <= lfsr_next_s;
      rcnt_r  <= rcnt_r + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      seg_r   <= seg_decode(digit_sel_s);
      anode_r <= ~(4'b0001 << sel_s);
    end
  end

  // Rolls are taken straight from the state register so they follow a seed in the same cycle
  assign bus.d0    = mod11(lfsr_r[7:0]);
  assign bus.d1    = mod11(lfsr_r[15:8]);
  assign bus.d2    = mod11(lfsr_r[23:16]);
  assign bus.d3    = mod11(lfsr_r[31:24]);
  assign bus.seg   = seg_r;
  assign bus.anode = anode_r;

endmodule

// File: tb/tb_dice_rng_display.sv
// Randomized self-checking bench for dice_rng_display against a cycle-level
// reference model of the roll generator and display scan.
module tb_dice_rng_display;

  localparam int          RB   = 4;
  localparam logic [31:0] SXOR = 32'hACE12B3D;

  logic clk;
  logic rst;
  dice_rng_display_if bus ();

  dice_rng_display #(.REFRESH_BITS(RB), .SEED_XOR(SXOR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic [3:0] anode_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // reference model state
  logic [31:0] m_cnt;
  logic [31:0] m_lfsr;
  int          m_rcnt;
  logic [6:0]  m_seg;
  logic [3:0]  m_anode;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] roll(input logic [31:0] s, input int i);
    int b;
    b = (s >> (8 * i)) & 255;
    return 4'(b % 11);
  endfunction

  task automatic model_reset();
    m_cnt   = 32'h0;
    m_lfsr  = 32'h1;
    m_rcnt  = 0;
    m_seg   = 7'h7F;
    m_anode = 4'hF;
  endtask

  task automatic check_all();
    check("d0", {28'h0, bus.d0}, {28'h0, roll(m_lfsr, 0)});
    check("d1", {28'h0, bus.d1}, {28'h0, roll(m_lfsr, 1)});
    check("d2", {28'h0, bus.d2}, {28'h0, roll(m_lfsr, 2)});
    check("d3", {28'h0, bus.d3}, {28'h0, roll(m_lfsr, 3)});
    check("seg", {25'h0, bus.seg}, {25'h0, m_seg});
    check("anode", {28'h0, bus.anode}, {28'h0, m_anode});
  endtask

  // one clock: model consumes current inputs, then outputs are compared at negedge
  task automatic tick();
    logic [3:0] dv [4];
    int sel;
    dv[0] = bus.digit0; dv[1] = bus.digit1; dv[2] = bus.digit2; dv[3] = bus.digit3;
    sel = m_rcnt / (1 << (RB - 2));
    m_seg   = seg_tab[dv[sel]];
    m_anode = anode_tab[sel];
    if (bus.seed_en) begin
      m_lfsr = ((m_cnt ^ SXOR) == 32'h0) ? 32'h1 : (m_cnt ^ SXOR);
    end else begin
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h80200003 : 32'h0);
    end
    m_cnt  = m_cnt + 32'd1;
    m_rcnt = (m_rcnt + 1) % (1 << RB);
    @(posedge clk);
    @(negedge clk);
    check_all();
    check("lfsr_nonzero", {31'h0, (m_lfsr != 32'h0)}, 32'h1);
  endtask

  // assert reset away from an edge, check dark display, release at a negedge
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("rst_d0", {28'h0, bus.d0}, 32'd1);
    check("rst_d1", {28'h0, bus.d1}, 32'd0);
    check("rst_d2", {28'h0, bus.d2}, 32'd0);
    check("rst_d3", {28'h0, bus.d3}, 32'd0);
    check("rst_seg", {25'h0, bus.seg}, 32'h7F);
    check("rst_anode", {28'h0, bus.anode}, 32'hF);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    bus.digit0 = a; bus.digit1 = b; bus.digit2 = c; bus.digit3 = d;
  endtask

  initial begin
    rst = 1'b0;
    bus.seed_en = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    model_reset();
    repeat (2) @(negedge clk);

    // first unseeded step
    do_reset();
    tick();
    check("step1_d", {16'h0, bus.d3, bus.d2, bus.d1, bus.d0}, 32'h7A03);

    // seed on the very first edge (cnt = 0)
    do_reset();
    bus.seed_en = 1'b1;
    tick();
    check("seed_d", {16'h0, bus.d3, bus.d2, bus.d1, bus.d0}, 32'h75A6);
    bus.seed_en = 1'b0;
    tick();

    // scan order with digits 1,2,3,10
    do_reset();
    set_digits(4'd1, 4'd2, 4'd3, 4'd10);
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 1 || c == 17) check("scan0", {21'h0, bus.anode, bus.seg}, {21'h0, 4'b1110, 7'h79});
      if (c == 5)  check("scan1", {21'h0, bus.anode, bus.seg}, {21'h0, 4'b1101, 7'h24});
      if (c == 9)  check("scan2", {21'h0, bus.anode, bus.seg}, {21'h0, 4'b1011, 7'h30});
      if (c == 13) check("scan3", {21'h0, bus.anode, bus.seg}, {21'h0, 4'b0111, 7'h3F});
    end

    // decode table through digit0 while sel = 0
    for (int v = 0; v < 16; v++) begin
      while ((m_rcnt / (1 << (RB - 2))) != 0) tick();
      bus.digit0 = 4'(v);
      tick();
      check("decode", {25'h0, bus.seg}, {25'h0, seg_tab[v]});
    end

    // randomized run with occasional re-seeding
    for (int i = 0; i < 3000; i++) begin
      set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      bus.seed_en = ($urandom_range(0, 99) < 3);
      tick();
      check("range", {31'h0, (bus.d0 <= 4'd10 && bus.d1 <= 4'd10 &&
                              bus.d2 <= 4'd10 && bus.d3 <= 4'd10)}, 32'h1);
    end
    bus.seed_en = 1'b0;

    // mid-operation asynchronous reset after a seed
    bus.seed_en = 1'b1;
    tick();
    bus.seed_en = 1'b0;
    repeat (6) tick();
    do_reset();
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
